// File: rtl/hazard_controller.sv
// Hazard unit for a five-stage pipeline: tracks the E/M/W producers and drives the stall, flush and forward controls.
// Define HAZARD_FORWARDING_EN to build operand forwarding; without it, any RAW hazard stalls until the producer retires.
module hazard_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    input  logic [1:0]  ResultSrcD,
    input  logic        PCSrcE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [15:0] StallCount
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regWrite;
        logic       isLoad;
    } slot_t;

    slot_t       slotE_q;
    slot_t       slotM_q;
    slot_t       slotW_q;
    logic [15:0] stallCount_q;
    logic [15:0] stallCount_d;

    logic        hazard;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        unusedSlotBits;

    // A slot only counts as the producer of r when it is live, writes back, and r is not x0.
    function automatic logic produces(input slot_t s, input logic [4:0] r);
        return s.valid && s.regWrite && (s.rd == r) && (r != 5'd0);
    endfunction

    // The load flag leaves the scoreboard from W without being consulted again.
    assign unusedSlotBits = slotW_q.isLoad;

`ifdef HAZARD_FORWARDING_EN
    logic [4:0] rs1E_q;
    logic [4:0] rs2E_q;

    always_comb begin
        fwdA   = 2'b00;
        fwdB   = 2'b00;
        hazard = 1'b0;
        if (produces(slotM_q, rs1E_q)) begin
            fwdA = 2'b10;
        end else if (produces(slotW_q, rs1E_q)) begin
            fwdA = 2'b01;
        end
        if (produces(slotM_q, rs2E_q)) begin
            fwdB = 2'b10;
        end else if (produces(slotW_q, rs2E_q)) begin
            fwdB = 2'b01;
        end
        // Load data only exists from W onward, so a load in E needs one bubble.
        if (slotE_q.isLoad && (produces(slotE_q, Rs1D) || produces(slotE_q, Rs2D))) begin
            hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1E_q <= 5'd0;
            rs2E_q <= 5'd0;
        end else if (FlushE) begin
            rs1E_q <= 5'd0;
            rs2E_q <= 5'd0;
        end else begin
            rs1E_q <= Rs1D;
            rs2E_q <= Rs2D;
        end
    end
`else
    always_comb begin
        fwdA   = 2'b00;
        fwdB   = 2'b00;
        hazard = 1'b0;
        // No bypass paths: wait until no in-flight instruction writes a Decode source.
        if (produces(slotE_q, Rs1D) || produces(slotE_q, Rs2D) ||
            produces(slotM_q, Rs1D) || produces(slotM_q, Rs2D) ||
            produces(slotW_q, Rs1D) || produces(slotW_q, Rs2D)) begin
            hazard = 1'b1;
        end
    end
`endif

    // A resolved branch discards both younger instructions, which makes any stall pointless.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            ForwardAE = fwdA;
            ForwardBE = fwdB;
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else begin
                StallF = hazard;
                StallD = hazard;
                FlushE = hazard;
            end
        end
    end

    assign stallCount_d = (StallD && (stallCount_q != 16'hFFFF)) ? stallCount_q + 16'd1 : stallCount_q;
    assign StallCount   = stallCount_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slotE_q      <= '0;
            slotM_q      <= '0;
            slotW_q      <= '0;
            stallCount_q <= 16'd0;
        end else begin
            slotW_q <= slotM_q;
            slotM_q <= slotE_q;
            if (FlushE) begin
                slotE_q <= '0;
            end else begin
                slotE_q.valid    <= 1'b1;
                slotE_q.rd       <= RdD;
                slotE_q.regWrite <= RegWriteD;
                slotE_q.isLoad   <= (ResultSrcD == 2'b01);
            end
            stallCount_q <= stallCount_d;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; expectations follow whichever build HAZARD_FORWARDING_EN selects.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  Rs1D = 5'd0;
    logic [4:0]  Rs2D = 5'd0;
    logic [4:0]  RdD = 5'd0;
    logic        RegWriteD = 1'b0;
    logic [1:0]  ResultSrcD = 2'b00;
    logic        PCSrcE = 1'b0;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [15:0] StallCount;

    int checkCount = 0;
    int errorCount = 0;

    hazard_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallCount (StallCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Control bits are compared as {StallF, StallD, FlushD, FlushE}.
    task automatic checkCtl(input string tag, input logic [3:0] expCtl, input logic [1:0] expA, input logic [1:0] expB);
        checkOutput({tag, " ctl"}, {12'd0, StallF, StallD, FlushD, FlushE}, {12'd0, expCtl});
        checkOutput({tag, " fwdA"}, {14'd0, ForwardAE}, {14'd0, expA});
        checkOutput({tag, " fwdB"}, {14'd0, ForwardBE}, {14'd0, expB});
    endtask

    // Drives one Decode cycle starting at a falling edge and lets the combinational outputs settle.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic regWrite, input logic [1:0] resultSrc, input logic pcSrc);
        @(negedge clk);
        Rs1D       = rs1;
        Rs2D       = rs2;
        RdD        = rd;
        RegWriteD  = regWrite;
        ResultSrcD = resultSrc;
        PCSrcE     = pcSrc;
        #1;
    endtask

    task automatic resetDut(input string tag);
        @(negedge clk);
        rst        = 1'b1;
        Rs1D       = 5'd0;
        Rs2D       = 5'd0;
        RdD        = 5'd0;
        RegWriteD  = 1'b0;
        ResultSrcD = 2'b00;
        PCSrcE     = 1'b0;
        @(negedge clk);
        #1;
        checkCtl({tag, " reset"}, 4'b0000, 2'b00, 2'b00);
        checkOutput({tag, " reset count"}, StallCount, 16'd0);
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] hazard_controller directed test");

        // ALU result consumed by the very next instruction.
        resetDut("alu");
        applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0);
        checkCtl("alu producer", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd5, 5'd0, 5'd8, 1'b1, 2'b00, 1'b0);
`ifdef HAZARD_FORWARDING_EN
        checkCtl("alu consumer D", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        checkCtl("alu consumer E", 4'b0000, 2'b10, 2'b00);
        checkOutput("alu count", StallCount, 16'd0);
`else
        checkCtl("alu stall 1", 4'b1101, 2'b00, 2'b00);
        applyStimulus(5'd5, 5'd0, 5'd8, 1'b1, 2'b00, 1'b0);
        checkCtl("alu stall 2", 4'b1101, 2'b00, 2'b00);
        applyStimulus(5'd5, 5'd0, 5'd8, 1'b1, 2'b00, 1'b0);
        checkCtl("alu stall 3", 4'b1101, 2'b00, 2'b00);
        applyStimulus(5'd5, 5'd0, 5'd8, 1'b1, 2'b00, 1'b0);
        checkCtl("alu released", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        checkCtl("alu consumer E", 4'b0000, 2'b00, 2'b00);
        checkOutput("alu count", StallCount, 16'd3);
`endif

        // Load followed by a use of its destination as rs2.
        resetDut("load");
        applyStimulus(5'd0, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0);
        checkCtl("load producer", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd6, 5'd9, 1'b1, 2'b00, 1'b0);
        checkCtl("load stall 1", 4'b1101, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd6, 5'd9, 1'b1, 2'b00, 1'b0);
`ifdef HAZARD_FORWARDING_EN
        checkCtl("load released", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        checkCtl("load consumer E", 4'b0000, 2'b00, 2'b01);
        checkOutput("load count", StallCount, 16'd1);
`else
        checkCtl("load stall 2", 4'b1101, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd6, 5'd9, 1'b1, 2'b00, 1'b0);
        checkCtl("load stall 3", 4'b1101, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd6, 5'd9, 1'b1, 2'b00, 1'b0);
        checkCtl("load released", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        checkCtl("load consumer E", 4'b0000, 2'b00, 2'b00);
        checkOutput("load count", StallCount, 16'd3);
`endif

        // x7 written by two back-to-back instructions, then consumed.
        resetDut("double");
        applyStimulus(5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0);
        applyStimulus(5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0);
        applyStimulus(5'd7, 5'd0, 5'd10, 1'b1, 2'b00, 1'b0);
`ifdef HAZARD_FORWARDING_EN
        checkCtl("double consumer D", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        checkCtl("double consumer E", 4'b0000, 2'b10, 2'b00);
`else
        checkCtl("double stall", 4'b1101, 2'b00, 2'b00);
`endif

        // x0 is never a real dependency.
        resetDut("x0");
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0);
        applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0);
        checkCtl("x0 use D", 4'b0000, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        checkCtl("x0 use E", 4'b0000, 2'b00, 2'b00);
        checkOutput("x0 count", StallCount, 16'd0);

        // Taken branch in the same cycle as a load-use hazard.
        resetDut("branch");
        applyStimulus(5'd0, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0);
        applyStimulus(5'd0, 5'd6, 5'd9, 1'b1, 2'b00, 1'b1);
        checkCtl("branch override", 4'b0011, 2'b00, 2'b00);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        checkCtl("branch after", 4'b0000, 2'b00, 2'b00);
        checkOutput("branch count", StallCount, 16'd0);

        // Reset raised while a stall is being requested.
        resetDut("midrst");
        applyStimulus(5'd0, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0);
        applyStimulus(5'd0, 5'd6, 5'd9, 1'b1, 2'b00, 1'b0);
        checkCtl("midrst stall", 4'b1101, 2'b00, 2'b00);
        rst = 1'b1;
        #1;
        checkCtl("midrst forced", 4'b0000, 2'b00, 2'b00);
        @(negedge clk);
        checkOutput("midrst count", StallCount, 16'd0);
        rst = 1'b0;
        #1;
        checkCtl("midrst first", 4'b0000, 2'b00, 2'b00);

        // Counter preloaded just below saturation, then pushed past it twice.
        resetDut("sat");
        @(negedge clk);
        force dut.stallCount_d = 16'hFFFE;
        @(negedge clk);
        release dut.stallCount_d;
        #1;
        checkOutput("sat preload", StallCount, 16'hFFFE);
        for (int round = 0; round < 2; round++) begin
            applyStimulus(5'd0, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0);
            for (int c = 0; c < 4; c++) begin
                applyStimulus(5'd0, 5'd6, 5'd9, 1'b1, 2'b00, 1'b0);
            end
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
            checkOutput("sat count", StallCount, 16'hFFFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
